// File: rtl/otter_pkg.sv
// otter_pkg: shared OTTER opcode, SYSTEM funct3 and control-unit state encodings
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        F3_PRIV   = 3'b000,
        F3_CSRRW  = 3'b001,
        F3_CSRRS  = 3'b010,
        F3_CSRRC  = 3'b011,
        F3_CSRRWI = 3'b101,
        F3_CSRRSI = 3'b110,
        F3_CSRRCI = 3'b111
    } funct3_system_t;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_INTR  = 3'd3,
        ST_ERR   = 3'd4
    } cu_state_t;

endpackage

// File: rtl/otter_cu_fsm_mc_if.sv
// otter_cu_fsm_mc_if: control-unit decode inputs, memory handshake and write strobes
interface otter_cu_fsm_mc_if;
    logic [6:0] CU_OPCODE;
    logic [2:0] CU_FUNC3;
    logic       CU_INT;
    logic       CU_MIE;
    logic       CU_MEM_RDY;
    logic       CU_IR_WE;
    logic       CU_PC_WRITE;
    logic       CU_REG_WRITE;
    logic       CU_MEM_RDEN1;
    logic       CU_MEM_RDEN2;
    logic       CU_MEM_WE2;
    logic       CU_CSR_WE;
    logic       CU_INT_TAKEN;
    logic       CU_MRET_EXEC;
    logic       CU_MEM_ERR;
    logic [2:0] CU_STATE;

    modport master (
        input  CU_OPCODE, CU_FUNC3, CU_INT, CU_MIE, CU_MEM_RDY,
        output CU_IR_WE, CU_PC_WRITE, CU_REG_WRITE, CU_MEM_RDEN1, CU_MEM_RDEN2,
               CU_MEM_WE2, CU_CSR_WE, CU_INT_TAKEN, CU_MRET_EXEC, CU_MEM_ERR, CU_STATE
    );

    modport slave (
        output CU_OPCODE, CU_FUNC3, CU_INT, CU_MIE, CU_MEM_RDY,
        input  CU_IR_WE, CU_PC_WRITE, CU_REG_WRITE, CU_MEM_RDEN1, CU_MEM_RDEN2,
               CU_MEM_WE2, CU_CSR_WE, CU_INT_TAKEN, CU_MRET_EXEC, CU_MEM_ERR, CU_STATE
    );
endinterface

// File: rtl/otter_cu_wait_timer.sv
// otter_cu_wait_timer: counts consecutive memory wait cycles and flags the last allowed one
module otter_cu_wait_timer #(
    parameter int MEM_LATENCY_MAX = 15
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr_i,
    input  logic cnt_i,
    output logic expired_o
);
    localparam int W = ($clog2(MEM_LATENCY_MAX + 1) < 1) ? 1 : $clog2(MEM_LATENCY_MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // next count: clear wins over increment
    always_comb cnt_d = clr_i ? '0 : cnt_i ? cnt_q + W'(1) : cnt_q;

    // wait-cycle counter
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    // high during the final permitted wait cycle; a zero limit never expires
    assign expired_o = (MEM_LATENCY_MAX != 0) && (cnt_q == W'(MEM_LATENCY_MAX - 1));
endmodule

// File: rtl/otter_cu_fsm_mc.sv
// otter_cu_fsm_mc: multicycle OTTER control FSM with variable-latency memory handshake
module otter_cu_fsm_mc
    import otter_pkg::*;
#(
    parameter int MEM_LATENCY_MAX = 15,
    parameter int HAS_INT         = 1
) (
    input logic               CLK,
    input logic               RST_N,
    otter_cu_fsm_mc_if.master cu
);
    cu_state_t state_q, state_d;
    logic      is_load_q, is_load_d;
    logic      rdy, int_req, waiting, expired, csr;
    logic      ir_we, pc_write, reg_write, rden1, rden2, we2, csr_we, int_taken, mret_exec, mem_err;

    assign rdy     = cu.CU_MEM_RDY;
    assign int_req = (HAS_INT != 0) & cu.CU_INT & cu.CU_MIE;
    assign waiting = (state_q == ST_FETCH || state_q == ST_MEM) && !rdy;
    assign csr     = cu.CU_FUNC3 != F3_PRIV;

    otter_cu_wait_timer #(.MEM_LATENCY_MAX(MEM_LATENCY_MAX)) u_timer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clr_i     (!waiting),
        .cnt_i     (waiting),
        .expired_o (expired)
    );

    // Mealy strobes and next state from the registered state plus RDY/INT
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        ir_we     = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        rden1     = 1'b0;
        rden2     = 1'b0;
        we2       = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        mem_err   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                rden1   = 1'b1;
                ir_we   = rdy;
                state_d = rdy ? ST_EXEC : expired ? ST_ERR : ST_FETCH;
            end
            ST_EXEC: begin
                pc_write = 1'b1;
                case (opcode_t'(cu.CU_OPCODE))
                    OP, OP_IMM, LUI, AUIPC, JAL, JALR: reg_write = 1'b1;
                    LOAD, STORE: begin
                        pc_write  = 1'b0;
                        is_load_d = cu.CU_OPCODE == LOAD;
                    end
                    SYSTEM: begin
                        reg_write = csr;
                        csr_we    = csr;
                        mret_exec = !csr;
                    end
                    default: ;
                endcase
                state_d = !pc_write ? ST_MEM : int_req ? ST_INTR : ST_FETCH;
            end
            ST_MEM: begin
                rden2     = is_load_q;
                we2       = !is_load_q;
                pc_write  = rdy;
                reg_write = rdy & is_load_q;
                state_d   = rdy ? (int_req ? ST_INTR : ST_FETCH) : expired ? ST_ERR : ST_MEM;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_ERR: mem_err = 1'b1;
            default: state_d = ST_FETCH;
        endcase
    end

    // state and access-type registers
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            state_q   <= ST_FETCH;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
        end

    assign cu.CU_IR_WE     = RST_N & ir_we;
    assign cu.CU_PC_WRITE  = RST_N & pc_write;
    assign cu.CU_REG_WRITE = RST_N & reg_write;
    assign cu.CU_MEM_RDEN1 = RST_N & rden1;
    assign cu.CU_MEM_RDEN2 = RST_N & rden2;
    assign cu.CU_MEM_WE2   = RST_N & we2;
    assign cu.CU_CSR_WE    = RST_N & csr_we;
    assign cu.CU_INT_TAKEN = RST_N & int_taken;
    assign cu.CU_MRET_EXEC = RST_N & mret_exec;
    assign cu.CU_MEM_ERR   = RST_N & mem_err;
    assign cu.CU_STATE     = RST_N ? state_q : ST_FETCH;
endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// tb_otter_cu_fsm_mc: directed scoreboard bench for the multicycle control FSM
module tb_otter_cu_fsm_mc;
    import otter_pkg::*;

    localparam logic [12:0] IRW = 13'h1000, PCW = 13'h0800, RGW = 13'h0400, RD1 = 13'h0200;
    localparam logic [12:0] RD2 = 13'h0100, WE2 = 13'h0080, CSW = 13'h0040, ITK = 13'h0020;
    localparam logic [12:0] MRT = 13'h0010, ERR = 13'h0008;
    localparam logic [12:0] SF = 13'd0, SE = 13'd1, SM = 13'd2, SI = 13'd3, SR = 13'd4;

    typedef struct {
        string       nm;
        bit          b;
        logic [12:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = 7'd0;
    logic [2:0]  f3 = 3'd0;
    logic        irq = 1'b0, mie = 1'b0, rdy = 1'b0;
    logic [12:0] va, vb;
    exp_t        q[$];
    exp_t        mr;
    int          n_chk = 0, n_fail = 0;

    otter_cu_fsm_mc_if ifa ();
    otter_cu_fsm_mc_if ifb ();

    assign ifa.CU_OPCODE  = op;
    assign ifa.CU_FUNC3   = f3;
    assign ifa.CU_INT     = irq;
    assign ifa.CU_MIE     = mie;
    assign ifa.CU_MEM_RDY = rdy;
    assign ifb.CU_OPCODE  = op;
    assign ifb.CU_FUNC3   = f3;
    assign ifb.CU_INT     = irq;
    assign ifb.CU_MIE     = mie;
    assign ifb.CU_MEM_RDY = rdy;

    otter_cu_fsm_mc #(.MEM_LATENCY_MAX(15), .HAS_INT(1)) dut (
        .CLK(clk), .RST_N(rst_n), .cu(ifa.master)
    );
    otter_cu_fsm_mc #(.MEM_LATENCY_MAX(15), .HAS_INT(0)) dut_ni (
        .CLK(clk), .RST_N(rst_n), .cu(ifb.master)
    );

    assign va = {ifa.CU_IR_WE, ifa.CU_PC_WRITE, ifa.CU_REG_WRITE, ifa.CU_MEM_RDEN1, ifa.CU_MEM_RDEN2,
                 ifa.CU_MEM_WE2, ifa.CU_CSR_WE, ifa.CU_INT_TAKEN, ifa.CU_MRET_EXEC, ifa.CU_MEM_ERR, ifa.CU_STATE};
    assign vb = {ifb.CU_IR_WE, ifb.CU_PC_WRITE, ifb.CU_REG_WRITE, ifb.CU_MEM_RDEN1, ifb.CU_MEM_RDEN2,
                 ifb.CU_MEM_WE2, ifb.CU_CSR_WE, ifb.CU_INT_TAKEN, ifb.CU_MRET_EXEC, ifb.CU_MEM_ERR, ifb.CU_STATE};

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (ir pc rg rd1 rd2 we2 csr itk mret err st[2:0])", nm, act, exp);
        end
    endtask

    // monitor: compare every queued expectation mid-cycle, away from the clock edge
    always @(negedge clk)
        while (q.size() != 0) begin
            mr = q.pop_front();
            check(mr.nm, mr.b ? vb : va, mr.exp);
        end

    // drive one cycle of inputs at posedge+1, queue expectations, advance to next posedge+1
    task automatic step(input string nm, input logic [6:0] o, input logic [2:0] f, input logic i,
                        input logic m, input logic r, input logic [12:0] ea, input logic [12:0] eb, input bit cb);
        op = o; f3 = f; irq = i; mie = m; rdy = r;
        q.push_back('{nm, 1'b0, ea});
        if (cb) q.push_back('{nm, 1'b1, eb});
        @(posedge clk); #1;
    endtask

    task automatic sa(input string nm, input logic [6:0] o, input logic [2:0] f, input logic i,
                      input logic m, input logic r, input logic [12:0] ea);
        step(nm, o, f, i, m, r, ea, 13'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; op = OP; f3 = 3'd0; irq = 1'b0; mie = 1'b0; rdy = 1'b1;
        #1;
        check("rst_a", va, 13'd0);
        check("rst_b", vb, 13'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        do_reset();
        sa("f_op",   OP,     3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("x_op",   OP,     3'd0, 0, 0, 1, RGW | PCW | SE);
        sa("f_lui",  LUI,    3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("x_lui",  LUI,    3'd0, 0, 0, 1, RGW | PCW | SE);
        sa("f_jalr", JALR,   3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("x_jalr", JALR,   3'd0, 0, 0, 1, RGW | PCW | SE);
        sa("f_br",   BRANCH, 3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("x_br",   BRANCH, 3'd0, 0, 0, 1, PCW | SE);
        sa("f_csr",  SYSTEM, 3'd1, 0, 0, 1, IRW | RD1 | SF);
        sa("x_csr",  SYSTEM, 3'd1, 0, 0, 1, RGW | CSW | PCW | SE);
        sa("f_mret", SYSTEM, 3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("x_mret", SYSTEM, 3'd0, 0, 0, 1, MRT | PCW | SE);
        sa("f_ill",  7'h7F,  3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("x_ill",  7'h7F,  3'd0, 0, 0, 1, PCW | SE);
        sa("fw1",    LOAD,   3'd0, 0, 0, 0, RD1 | SF);
        sa("fw2",    LOAD,   3'd0, 0, 0, 0, RD1 | SF);
        sa("f_ld",   LOAD,   3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("x_ld",   LOAD,   3'd0, 0, 0, 1, SE);
        repeat (4) sa("ld_wait", LOAD, 3'd0, 0, 0, 0, RD2 | SM);
        sa("ld_done", LOAD,  3'd0, 0, 0, 1, RD2 | RGW | PCW | SM);
        sa("f_st",   STORE,  3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("x_st",   STORE,  3'd0, 0, 0, 1, SE);
        sa("st_done", STORE, 3'd0, 0, 0, 1, WE2 | PCW | SM);
        sa("f_after", OP,    3'd0, 0, 0, 1, IRW | RD1 | SF);

        do_reset();
        repeat (15) sa("to_wait", OP, 3'd0, 0, 0, 0, RD1 | SF);
        sa("to_err",  OP, 3'd0, 0, 0, 0, ERR | SR);
        sa("to_hold", OP, 3'd0, 0, 0, 1, ERR | SR);
        sa("to_hold", OP, 3'd0, 1, 1, 1, ERR | SR);

        do_reset();
        repeat (14) sa("tl_wait", OP, 3'd0, 0, 0, 0, RD1 | SF);
        sa("tl_last", OP,   3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("tl_exec", OP,   3'd0, 0, 0, 1, RGW | PCW | SE);
        sa("dt_f",    LOAD, 3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("dt_x",    LOAD, 3'd0, 0, 0, 0, SE);
        repeat (15) sa("dt_wait", LOAD, 3'd0, 0, 0, 0, RD2 | SM);
        sa("dt_err",  LOAD, 3'd0, 0, 0, 1, ERR | SR);

        do_reset();
        step("i_fw", OP, 3'd0, 1, 1, 0, RD1 | SF,       RD1 | SF,       1'b1);
        step("i_f",  OP, 3'd0, 1, 1, 1, IRW | RD1 | SF, IRW | RD1 | SF, 1'b1);
        step("i_x",  OP, 3'd0, 1, 1, 1, RGW | PCW | SE, RGW | PCW | SE, 1'b1);
        step("i_tk", OP, 3'd0, 1, 1, 1, ITK | PCW | SI, IRW | RD1 | SF, 1'b1);
        step("i_f2", OP, 3'd0, 1, 1, 1, IRW | RD1 | SF, RGW | PCW | SE, 1'b1);
        step("i_x2", OP, 3'd0, 0, 0, 1, RGW | PCW | SE, IRW | RD1 | SF, 1'b1);

        do_reset();
        sa("m_f",  OP,     3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("m_x",  SYSTEM, 3'd0, 1, 1, 1, MRT | PCW | SE);
        sa("m_tk", SYSTEM, 3'd0, 1, 1, 1, ITK | PCW | SI);
        sa("m_f2", OP,     3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("n_x",  OP,     3'd0, 1, 0, 1, RGW | PCW | SE);
        sa("n_f",  OP,     3'd0, 1, 0, 1, IRW | RD1 | SF);
        sa("li_x", LOAD,   3'd0, 0, 0, 1, SE);
        sa("li_w", LOAD,   3'd0, 1, 1, 0, RD2 | SM);
        sa("li_d", LOAD,   3'd0, 1, 1, 1, RD2 | RGW | PCW | SM);
        sa("li_tk", OP,    3'd0, 0, 0, 1, ITK | PCW | SI);
        sa("li_f", OP,     3'd0, 0, 0, 1, IRW | RD1 | SF);

        do_reset();
        sa("s_f", STORE, 3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("s_x", STORE, 3'd0, 0, 0, 1, SE);
        sa("s_w", STORE, 3'd0, 0, 0, 0, WE2 | SM);
        #1 check("s_pre", va, WE2 | SM);
        #1 rst_n = 1'b0;
        #1 check("s_drop", va, 13'd0);
        @(posedge clk); #1;
        check("s_held", va, 13'd0);
        rst_n = 1'b1;
        sa("s_f2", OP, 3'd0, 0, 0, 1, IRW | RD1 | SF);
        sa("s_x2", OP, 3'd0, 0, 0, 1, RGW | PCW | SE);

        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
